// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one MSB-first parallel-in/serial-out path among NUM_REQ producers.
// Optional build macro PISO_PARITY_EN appends one even-parity bit to every frame.
module piso_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ser_out,
  output logic                      ser_valid,
  output logic                      frame_start,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

`ifdef PISO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int LAST_BIT = DATA_W - 1 + PAR_BITS;
  localparam int CNT_W    = $clog2(DATA_W + 1) + 1;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [DATA_W-1:0]   shift_r;
  logic [CNT_W-1:0]    bit_cnt_r;
  logic [GAP_W-1:0]    gap_cnt_r;
  logic [ID_W-1:0]     ptr_r;
  logic [ID_W-1:0]     grant_r;
  logic [ID_W-1:0]     win_idx_s;
  logic [ID_W-1:0]     cand_s;
  logic                any_valid_s;
  logic [NUM_REQ-1:0]  grant_onehot_s;
  logic [DATA_W-1:0]   words_s [NUM_REQ];

`ifdef PISO_PARITY_EN
  logic                parity_r;

  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign words_s[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign any_valid_s    = |req_valid;
  assign grant_onehot_s = ONE_HOT0 << win_idx_s;
  assign grant_id       = grant_r;
  assign busy           = (state_r != ST_IDLE);

  // Round-robin winner: descending sweep so the nearest valid index after ptr_r is written last.
  always_comb begin
    win_idx_s = ptr_r;
    cand_s    = ptr_r;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand_s    = ID_W'((int'(ptr_r) + off) % NUM_REQ);
      win_idx_s = req_valid[cand_s] ? cand_s : win_idx_s;
    end
  end

  // Next-state decode and the combinational accept pulse, only ever raised in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = {NUM_REQ{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          req_ready   = grant_onehot_s;
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_r == CNT_W'(LAST_BIT)) begin
          state_nxt_s = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_W'(GAP_LAST)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Serial outputs decode purely from registered state, so reset clears them asynchronously.
  always_comb begin
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    if (state_r == ST_SHIFT) begin
      ser_valid   = 1'b1;
      frame_start = (bit_cnt_r == {CNT_W{1'b0}});
`ifdef PISO_PARITY_EN
      ser_out     = (bit_cnt_r == CNT_W'(DATA_W)) ? parity_r : shift_r[DATA_W-1];
`else
      ser_out     = shift_r[DATA_W-1];
`endif
    end else begin
      ser_out     = 1'b0;
      ser_valid   = 1'b0;
      frame_start = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: load on grant, shift during the frame, count the idle gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r   <= {DATA_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
      ptr_r     <= ID_W'(NUM_REQ - 1);
      grant_r   <= {ID_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_valid_s) begin
            shift_r   <= words_s[win_idx_s];
            ptr_r     <= win_idx_s;
            grant_r   <= win_idx_s;
            bit_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_SHIFT: begin
          shift_r   <= {shift_r[DATA_W-2:0], 1'b0};
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          gap_cnt_r <= {GAP_W{1'b0}};
        end
        ST_GAP: begin
          gap_cnt_r <= gap_cnt_r + GAP_W'(1);
        end
        default: begin
          gap_cnt_r <= {GAP_W{1'b0}};
        end
      endcase
    end
  end

`ifdef PISO_PARITY_EN
  // Parity is captured with the word because the shift register has drained by the final bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_r <= 1'b0;
    end else if (state_r == ST_IDLE && any_valid_s) begin
      parity_r <= even_parity(words_s[win_idx_s]);
    end
  end
`endif

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Self-checking bench for piso_tx_scheduler: directed table, hand sequences and a queue-based reference model.
module tb_piso_tx_scheduler;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int GC = 1;
`ifdef PISO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FLEN = DW + PB;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              ser_out, ser_valid, frame_start, busy;
  logic [1:0]        grant_id;

  logic [NR-1:0]     z_valid;
  logic [NR*DW-1:0]  z_data;
  logic [NR-1:0]     z_ready;
  logic              z_ser_out, z_ser_valid, z_frame_start, z_busy;
  logic [1:0]        z_grant_id;

  piso_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_start(frame_start), .grant_id(grant_id), .busy(busy)
  );

  piso_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .reset_n(reset_n), .req_valid(z_valid), .req_data(z_data),
    .req_ready(z_ready), .ser_out(z_ser_out), .ser_valid(z_ser_valid),
    .frame_start(z_frame_start), .grant_id(z_grant_id), .busy(z_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of expected serial slots; an empty queue means the scheduler is idle.
  typedef struct packed { logic v; logic d; logic fs; } slot_t;
  slot_t q[$];
  int    rr;
  int    gid;
  int    cyc_n;
  int    hs_cyc[$];
  int    hs_id[$];
  logic  last_so, last_sv;

  task automatic model_reset();
    q.delete();
    rr  = NR - 1;
    gid = 0;
  endtask

  function automatic int pick(input logic [NR-1:0] v);
    for (int off = 1; off <= NR; off++) begin
      if (v[(rr + off) % NR]) return (rr + off) % NR;
    end
    return -1;
  endfunction

  task automatic step(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input string tag);
    slot_t         e;
    int            w;
    logic [NR-1:0] er;
    logic [NR-1:0] one;
    logic          eb;
    logic [DW-1:0] word;
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    #1;
    one = 1;
    if (q.size() > 0) begin
      e = q.pop_front(); er = '0; eb = 1'b1; w = -1;
    end else begin
      e = '0; eb = 1'b0; w = pick(v);
      er = (w >= 0) ? (one << w) : '0;
    end
    chk({tag, ".ready"}, 32'(req_ready), 32'(er));
    chk({tag, ".ser_valid"}, 32'(ser_valid), 32'(e.v));
    chk({tag, ".ser_out"}, 32'(ser_out), 32'(e.d));
    chk({tag, ".frame_start"}, 32'(frame_start), 32'(e.fs));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".grant_id"}, 32'(grant_id), 32'(gid));
    last_so = ser_out;
    last_sv = ser_valid;
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] === 1'b1) begin
        hs_cyc.push_back(cyc_n);
        hs_id.push_back(i);
      end
    end
    cyc_n++;
    if (w >= 0) begin
      rr   = w;
      gid  = w;
      word = d[w*DW +: DW];
      for (int b = DW - 1; b >= 0; b--) q.push_back(slot_t'{1'b1, word[b], (b == DW - 1)});
`ifdef PISO_PARITY_EN
      q.push_back(slot_t'{1'b1, ^word, 1'b0});
`endif
      repeat (GC) q.push_back(slot_t'{1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = '0;
    z_valid   = '0;
    #1;
    chk("rst.ready", 32'(req_ready), 32'h0);
    chk("rst.ser_out", 32'(ser_out), 32'h0);
    chk("rst.ser_valid", 32'(ser_valid), 32'h0);
    chk("rst.frame_start", 32'(frame_start), 32'h0);
    chk("rst.grant_id", 32'(grant_id), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] ready;
    logic          so, sv, fs, bz;
    logic [1:0]    gid;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [NR-1:0] v, input logic [NR-1:0] r, input logic so,
                     input logic sv, input logic fs, input logic bz, input logic [1:0] g);
    tbl.push_back('{valid: v, ready: r, so: so, sv: sv, fs: fs, bz: bz, gid: g});
  endtask

  logic [NR*DW-1:0] dat;
  logic [7:0]       a5;
  int               prev_sv, run_len, seen_high, id1;
  int               z_hs[$];

  initial begin
    reset_n = 1'b0; req_valid = '0; req_data = '0; z_valid = '0; z_data = '0;
    cyc_n = 0; last_so = 1'b0; last_sv = 1'b0;
    model_reset();

    // Directed table: A5 frame from requester 0, gap, then requester 2 wins the next search.
    a5 = 8'hA5;
    add(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int b = 7; b >= 0; b--) add(4'b0000, 4'b0000, a5[b], 1'b1, (b == 7), 1'b1, 2'd0);
`ifdef PISO_PARITY_EN
    add(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
`endif
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    add(4'b0101, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);

    do_reset();
    req_data = {8'h44, 8'hC3, 8'h22, 8'hA5};
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      req_valid = tbl[i].valid;
      #1;
      chk($sformatf("tbl%0d.ready", i), 32'(req_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d.ser_out", i), 32'(ser_out), 32'(tbl[i].so));
      chk($sformatf("tbl%0d.ser_valid", i), 32'(ser_valid), 32'(tbl[i].sv));
      chk($sformatf("tbl%0d.frame_start", i), 32'(frame_start), 32'(tbl[i].fs));
      chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].bz));
      chk($sformatf("tbl%0d.grant_id", i), 32'(grant_id), 32'(tbl[i].gid));
    end

    // Round robin with all four requesters held valid.
    do_reset();
    hs_cyc.delete(); hs_id.delete();
    dat = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (5 * (FLEN + GC + 1)) step(4'b1111, dat, "rr");
    chk("rr.count", 32'(hs_id.size() >= 5), 32'h1);
    if (hs_id.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("rr.order%0d", i), 32'(hs_id[i]), 32'(i % NR));
      for (int i = 0; i < 4; i++) chk($sformatf("rr.space%0d", i), 32'(hs_cyc[i+1] - hs_cyc[i]), 32'(FLEN + GC + 1));
    end

    // Requester 1 rises mid-frame; it must wait for IDLE and then win after wrap-around.
    do_reset();
    hs_cyc.delete(); hs_id.delete();
    dat = {8'h00, 8'h5A, 8'h3C, 8'h00};
    step(4'b0100, dat, "late");
    repeat (3) step(4'b0000, dat, "late");
    repeat (12) step(4'b0010, dat, "late");
    chk("late.count", 32'(hs_id.size()), 32'd2);
    id1 = (hs_id.size() >= 2) ? hs_id[1] : -1;
    chk("late.second_id", 32'(id1), 32'd1);
    chk("late.space", 32'((hs_cyc.size() >= 2) ? hs_cyc[1] - hs_cyc[0] : -1), 32'(FLEN + GC + 1));

    // Reset during bit 4 of a frame, then requesters 0 and 3 compete.
    do_reset();
    dat = {8'h00, 8'h00, 8'h00, 8'hFF};
    step(4'b0001, dat, "mid");
    repeat (4) step(4'b0000, dat, "mid");
    @(negedge clk);
    #2;
    chk("mid.pre_sv", 32'(ser_valid), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid.ser_valid", 32'(ser_valid), 32'h0);
    chk("mid.ser_out", 32'(ser_out), 32'h0);
    chk("mid.busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    dat = {8'h99, 8'h00, 8'h00, 8'h66};
    step(4'b1001, dat, "mid.after");
    chk("mid.first_grant", 32'(req_ready), 32'h1);
    repeat (FLEN + GC + 1) step(4'b0000, dat, "mid.drain");

    // Zero-gap instance: back-to-back frames from requester 0.
    do_reset();
    z_data = {8'h00, 8'h00, 8'h00, 8'hE7};
    z_valid = 4'b0001;
    prev_sv = 0; run_len = 0; seen_high = 0;
    for (int c = 0; c < 4 * (FLEN + 1) + 2; c++) begin
      @(negedge clk);
      #1;
      if (z_ready[0] === 1'b1) z_hs.push_back(c);
      if (z_ser_valid === 1'b1) begin
        if (seen_high != 0 && prev_sv == 0) chk("g0.low_run", 32'(run_len), 32'd1);
        seen_high = 1;
        run_len   = 0;
      end else begin
        run_len++;
      end
      prev_sv = int'(z_ser_valid);
    end
    z_valid = '0;
    chk("g0.count", 32'(z_hs.size() >= 4), 32'h1);
    for (int i = 0; i + 1 < z_hs.size(); i++) chk($sformatf("g0.space%0d", i), 32'(z_hs[i+1] - z_hs[i]), 32'(FLEN + 1));

`ifdef PISO_PARITY_EN
    // Parity bit for an odd and an even number of ones.
    do_reset();
    dat = {8'h00, 8'h00, 8'h00, 8'h07};
    step(4'b0001, dat, "par7");
    repeat (FLEN) step(4'b0000, dat, "par7");
    chk("par7.last_sv", 32'(last_sv), 32'h1);
    chk("par7.last_bit", 32'(last_so), 32'h1);
    repeat (GC) step(4'b0000, dat, "par7");
    dat = {8'h00, 8'h00, 8'h00, 8'h03};
    step(4'b0001, dat, "par3");
    repeat (FLEN) step(4'b0000, dat, "par3");
    chk("par3.last_bit", 32'(last_so), 32'h0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [NR-1:0] v;
      v = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom_range(0, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) dat[i*DW +: DW] = DW'($urandom);
      step(v, dat, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_tx_scheduler.md
Name: piso_tx_scheduler

Overview:
Round-robin scheduler that shares one parallel-in/serial-out shift path among NUM_REQ requesters. It accepts one parallel word per grant over a valid/ready handshake, loads it, and shifts it out MSB-first with a frame-start strobe. It then inserts an optional idle gap before arbitrating again. It sits between several parallel producers and a single serial output pin or link.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, bits per word (2..32)
GAP_CYCLES, 1, idle cycles after each frame before re-arbitration (0 allowed)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester word available
req_data  input  NUM_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant/accept pulse
ser_out  output  1  serial data, MSB first
ser_valid  output  1  high while ser_out carries a frame bit
frame_start  output  1  high with the first bit of each frame
grant_id  output  clog2(NUM_REQ) (min 1)  index of the requester owning the current or last frame
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE, shift_reg=0, bit counter=0, gap counter=0, rr pointer=NUM_REQ-1 (requester 0 wins first). Outputs: ser_out=0, ser_valid=0, frame_start=0, req_ready=0, grant_id=0, busy=0.
- States: IDLE, SHIFT, GAP.
- IDLE with any req_valid high:
  - The winner g is the first valid index searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that cycle; all other ready bits are 0.
  - On that edge: shift_reg<=req_data[g], ptr<=g, grant_id<=g, bit counter<=0, state<=SHIFT.
  - req_ready is never high outside IDLE. At most one handshake per frame.
- IDLE with no valid: remain in IDLE, all outputs idle.
- SHIFT:
  - ser_out=shift_reg[DATA_W-1]; ser_valid=1; frame_start=1 only when bit counter==0.
  - Each edge shifts left, filling with 0, and increments the counter.
  - After DATA_W bits: go to GAP if GAP_CYCLES>0, otherwise go to IDLE.
- Latency: handshake edge k puts the MSB on ser_out during cycle k+1. The frame occupies cycles k+1..k+DATA_W.
- GAP: ser_out=0, ser_valid=0 for exactly GAP_CYCLES cycles, then IDLE. The next grant can therefore occur in the first IDLE cycle.
- Back-to-back throughput: one word per DATA_W+GAP_CYCLES+1 cycles.
- Fairness: a continuously asserted requester is granted again only after every other simultaneously valid requester has been served once.
- req_valid changes during SHIFT/GAP are ignored; the data is sampled only at the handshake edge.
- A requester that drops valid before the grant is simply skipped; no state is held for it.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is abandoned; ser_valid drops asynchronously.
- Outputs ser_out, ser_valid and frame_start are derived from registers only; no combinational path from req_valid.

Optional Feature:
PISO_PARITY_EN
- Defined: after the DATA_W data bits, one extra SHIFT cycle drives an even-parity bit (XOR of the loaded word) with ser_valid=1 and frame_start=0. The frame is DATA_W+1 bits long.
- Undefined: no parity logic; the frame is exactly DATA_W bits.

Test Plan:
- Reset, then req_valid=4'b0001, req_data[0]=8'hA5 -> req_ready[0] pulses one cycle. Next 8 cycles ser_out=1,0,1,0,0,1,0,1, ser_valid=1, frame_start only on the first bit. Then 1 GAP cycle, then busy=0.
- All four valid continuously, words 8'h11/22/33/44 -> grants in order 0,1,2,3,0. The serial stream matches each word. Handshakes are 10 cycles apart.
- Requester 2 valid only, then requester 1 asserts mid-frame -> requester 1 is not granted until IDLE. The next grant goes to 1, since the search starts at ptr+1=3, wraps, and 1 is the only valid.
- reset_n pulled low during bit 4 of a frame -> ser_valid, ser_out and busy go 0 immediately. After release with requesters 0 and 3 valid, requester 0 is granted first.
- GAP_CYCLES=0, requester 0 always valid -> handshakes every 9 cycles and ser_valid is low for exactly 1 cycle between frames.
- PISO_PARITY_EN defined, word 8'h07 -> 9 valid bits, final bit=1 (odd count of ones gives parity 1). Word 8'h03 -> final bit=0.
